// File: rtl/instr_executor.sv
// instr_executor: fetches host instruction words and runs register-file, DAC and ADC SPI operations,
// returning read results through a flow-controlled readback port with sticky error flags.
module instr_executor #(
  parameter int N_REGS      = 16,
  parameter int REG_W       = 16,
  parameter int N_DAC       = 32,
  parameter int DAC_W       = 12,
  parameter int ADC_AW      = 16,
  parameter int ADC_DW      = 8,
  parameter int SPI_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_ready,
  output logic              instr_ack,
  input  logic [31:0]       instr_in,
  input  logic              readback_ready,
  output logic              readback_write,
  output logic [31:0]       readback_data,
  output logic              dac_request_write,
  output logic [4:0]        dac_address,
  output logic [DAC_W-1:0]  dac_data,
  output logic              adc_request_write,
  output logic              adc_request_read,
  output logic [ADC_AW-1:0] adc_address,
  output logic [ADC_DW-1:0] adc_data,
  input  logic [ADC_DW-1:0] adc_data_readback,
  input  logic              spi_busy,
  output logic [2:0]        err_flags,
  output logic [2:0]        cu_state,
  output logic [4:0]        cu_instr
);
  localparam int RA_W = $clog2(N_REGS);
  localparam int DA_W = N_DAC > 1 ? $clog2(N_DAC) : 1;
  localparam int TM_W = $clog2(SPI_TIMEOUT);
  localparam logic [4:0] OP_NOP = 5'd0, OP_WR = 5'd1, OP_RD = 5'd2, OP_CLR = 5'd3;
  localparam logic [1:0] SEL_ADC = 2'd0, SEL_DAC = 2'd1, SEL_INT = 2'd2;
  typedef enum logic [2:0] {IDLE, DECODE, WAIT_START, WAIT_BUSY, READBACK} state_t;
  state_t              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [15:0]         data_q, data_d;
  logic [TM_W-1:0]     timer_q, timer_d;
  logic [2:0]          err_q, err_d;
  logic [REG_W-1:0]    regs_q [N_REGS];
  logic [REG_W-1:0]    regs_d [N_REGS];
  logic [DAC_W-1:0]    shadow_q [N_DAC];
  logic [DAC_W-1:0]    shadow_d [N_DAC];
  logic                ack_q, ack_d, rbw_q, rbw_d;
  logic                dac_wr_q, dac_wr_d, adc_wr_q, adc_wr_d, adc_rd_q, adc_rd_d;
  logic [4:0]          dac_addr_q, dac_addr_d;
  logic [DAC_W-1:0]    dac_data_q, dac_data_d;
  logic [ADC_AW-1:0]   adc_addr_q, adc_addr_d;
  logic [ADC_DW-1:0]   adc_data_q, adc_data_d;
  logic [4:0]          op;
  logic [1:0]          sel;
  logic [RA_W-1:0]     ra;
  logic [4:0]          ch;
  logic                ch_ok;
  assign op    = instr_q[31:27];
  assign sel   = instr_q[26:25];
  assign ra    = instr_q[20 +: RA_W];
  assign ch    = instr_q[24:20];
  assign ch_ok = 32'(ch) < N_DAC;
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    data_d     = data_q;
    timer_d    = timer_q;
    err_d      = err_q;
    regs_d     = regs_q;
    shadow_d   = shadow_q;
    ack_d      = 1'b0;
    rbw_d      = 1'b0;
    dac_wr_d   = 1'b0;
    adc_wr_d   = 1'b0;
    adc_rd_d   = 1'b0;
    dac_addr_d = dac_addr_q;
    dac_data_d = dac_data_q;
    adc_addr_d = adc_addr_q;
    adc_data_d = adc_data_q;
    case (state_q)
      IDLE: if (instr_ready) begin
        instr_d = instr_in;
        ack_d   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        if (op == OP_CLR) err_d = '0;
        else if ((op == OP_WR || op == OP_RD) && sel != 2'd3) begin
          if (sel == SEL_INT) begin
            if (op == OP_WR) regs_d[ra] = instr_q[REG_W-1:0];
            else begin
              data_d  = 16'(regs_q[ra]);
              state_d = READBACK;
            end
          end else if (sel == SEL_DAC) begin
            // an out-of-range channel never reaches the SPI master
            if (!ch_ok) err_d[1] = 1'b1;
            else if (op == OP_WR) begin
              dac_wr_d = 1'b1;
              dac_addr_d = ch;
              dac_data_d = instr_q[DAC_W-1:0];
              shadow_d[ch[DA_W-1:0]] = instr_q[DAC_W-1:0];
              state_d = WAIT_START;
            end
            if (op == OP_RD) begin
              data_d  = ch_ok ? 16'(shadow_q[ch[DA_W-1:0]]) : 16'h0;
              state_d = READBACK;
            end
          end else begin
            adc_wr_d   = op == OP_WR;
            adc_rd_d   = op == OP_RD;
            adc_addr_d = instr_q[8 +: ADC_AW];
            adc_data_d = op == OP_WR ? instr_q[ADC_DW-1:0] : adc_data_q;
            state_d    = WAIT_START;
          end
        end else if (op != OP_NOP) err_d[0] = 1'b1;
      end
      WAIT_START: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // busy dropping on the final timer cycle still counts as success
        if (!spi_busy) begin
          state_d = op == OP_RD ? READBACK : IDLE;
          data_d  = op == OP_RD ? 16'(adc_data_readback) : data_q;
        end else if (timer_q == TM_W'(SPI_TIMEOUT - 1)) begin
          err_d[2] = 1'b1;
          state_d  = IDLE;
        end else timer_d = timer_q + 1'b1;
      end
      READBACK: if (readback_ready) begin
        rbw_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      err_q      <= '0;
      ack_q      <= 1'b0;
      rbw_q      <= 1'b0;
      dac_wr_q   <= 1'b0;
      adc_wr_q   <= 1'b0;
      adc_rd_q   <= 1'b0;
      dac_addr_q <= '0;
      dac_data_q <= '0;
      adc_addr_q <= '0;
      adc_data_q <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
      for (int i = 0; i < N_DAC; i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      rbw_q      <= rbw_d;
      dac_wr_q   <= dac_wr_d;
      adc_wr_q   <= adc_wr_d;
      adc_rd_q   <= adc_rd_d;
      dac_addr_q <= dac_addr_d;
      dac_data_q <= dac_data_d;
      adc_addr_q <= adc_addr_d;
      adc_data_q <= adc_data_d;
      regs_q     <= regs_d;
      shadow_q   <= shadow_d;
    end
  end
  assign instr_ack         = ack_q;
  assign readback_write    = rbw_q;
  assign readback_data     = {instr_q[31:20], 4'h0, data_q};
  assign dac_request_write = dac_wr_q;
  assign dac_address       = dac_addr_q;
  assign dac_data          = dac_data_q;
  assign adc_request_write = adc_wr_q;
  assign adc_request_read  = adc_rd_q;
  assign adc_address       = adc_addr_q;
  assign adc_data          = adc_data_q;
  assign err_flags         = err_q;
  assign cu_state          = state_q;
  assign cu_instr          = op;
endmodule

// File: tb/tb_instr_executor.sv
// tb_instr_executor: directed scenarios for instr_executor with hand-computed expectations.
module tb_instr_executor;
  logic        clk = 0, reset = 1, instr_ready = 0, readback_ready = 1, spi_busy = 0;
  logic [31:0] instr_in = 0;
  logic [7:0]  adc_data_readback = 0;
  logic        instr_ack, readback_write, dac_request_write, adc_request_write, adc_request_read;
  logic [31:0] readback_data;
  logic [4:0]  dac_address, cu_instr;
  logic [11:0] dac_data;
  logic [15:0] adc_address;
  logic [7:0]  adc_data;
  logic [2:0]  err_flags, cu_state;
  int n_checks = 0, n_pass = 0;
  int cyc = 0, ack_cnt = 0, wr_cnt = 0, dac_cnt = 0, adc_rd_cnt = 0;
  instr_executor #(.N_DAC(16)) dut (
    .clk(clk), .reset(reset), .instr_ready(instr_ready), .instr_ack(instr_ack), .instr_in(instr_in),
    .readback_ready(readback_ready), .readback_write(readback_write), .readback_data(readback_data),
    .dac_request_write(dac_request_write), .dac_address(dac_address), .dac_data(dac_data),
    .adc_request_write(adc_request_write), .adc_request_read(adc_request_read),
    .adc_address(adc_address), .adc_data(adc_data), .adc_data_readback(adc_data_readback),
    .spi_busy(spi_busy), .err_flags(err_flags), .cu_state(cu_state), .cu_instr(cu_instr)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    ack_cnt    <= ack_cnt + int'(instr_ack);
    wr_cnt     <= wr_cnt + int'(readback_write);
    dac_cnt    <= dac_cnt + int'(dac_request_write);
    adc_rd_cnt <= adc_rd_cnt + int'(adc_request_read);
  end
  function automatic logic [89:0] all_outs();
    return {instr_ack, readback_write, readback_data, dac_request_write, dac_address, dac_data,
            adc_request_write, adc_request_read, adc_address, adc_data, err_flags, cu_state, cu_instr};
  endfunction
  task automatic issue(input logic [31:0] w);
    int k = 0;
    instr_in = w;
    instr_ready = 1;
    @(negedge clk);
    while (!instr_ack && k < 200) begin @(negedge clk); k++; end
    instr_ready = 0;
    n_checks++;
    if (instr_ack !== 1'b1) $display("FAIL ack_wait word=%h ack=%b want 1", w, instr_ack); else n_pass++;
  endtask
  task automatic wait_rb(output logic [31:0] d);
    int k = 0;
    while (!readback_write && k < 100) begin @(negedge clk); k++; end
    d = readback_write ? readback_data : 32'hxxxx_xxxx;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (cu_state != 0 && k < 2000) begin @(negedge clk); k++; end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset_outs got %h want 0", all_outs()); else n_pass++;
    reset = 0;
    @(negedge clk);
    n_checks++;
    if (cu_state !== 3'd0) $display("FAIL reset_state got %0d want 0", cu_state); else n_pass++;
  endtask
  task automatic test_back_to_back();
    int t0, k = 0;
    instr_in = 32'h0;
    instr_ready = 1;
    @(negedge clk);
    while (!instr_ack && k < 50) begin @(negedge clk); k++; end
    t0 = cyc;
    @(negedge clk);
    k = 0;
    while (!instr_ack && k < 50) begin @(negedge clk); k++; end
    instr_ready = 0;
    n_checks++;
    if (cyc - t0 !== 2) $display("FAIL noop_latency got %0d want 2", cyc - t0); else n_pass++;
    wait_idle();
  endtask
  task automatic test_int();
    logic [31:0] d;
    int w0;
    issue(32'h0C30_BEEF);
    wait_idle();
    w0 = wr_cnt;
    issue(32'h1430_0000);
    wait_rb(d);
    n_checks++;
    if (d !== 32'h1430_BEEF) $display("FAIL int_read got %h want 1430beef", d); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_cnt - w0 !== 1) $display("FAIL int_write_count got %0d want 1", wr_cnt - w0); else n_pass++;
  endtask
  task automatic test_dac();
    logic [31:0] d;
    int t0, d0, k = 0;
    d0 = dac_cnt;
    issue(32'h0A50_07FF);
    t0 = cyc;
    instr_in = 32'h0;
    instr_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({dac_request_write, dac_address, dac_data} !== {1'b1, 5'd5, 12'h7FF})
      $display("FAIL dac_strobe got %b/%0d/%h want 1/5/7ff", dac_request_write, dac_address, dac_data);
    else n_pass++;
    spi_busy = 1;
    repeat (10) @(negedge clk);
    spi_busy = 0;
    while (!instr_ack && k < 100) begin @(negedge clk); k++; end
    instr_ready = 0;
    n_checks++;
    if (!instr_ack || cyc - t0 < 12) $display("FAIL dac_next_ack got %0d want >=12", cyc - t0); else n_pass++;
    wait_idle();
    n_checks++;
    if (dac_cnt - d0 !== 1) $display("FAIL dac_count got %0d want 1", dac_cnt - d0); else n_pass++;
    issue(32'h1250_0000);
    wait_rb(d);
    n_checks++;
    if (d !== 32'h1250_07FF) $display("FAIL dac_read got %h want 125007ff", d); else n_pass++;
    wait_idle();
  endtask
  task automatic test_adc_read();
    logic [31:0] d;
    int a0;
    a0 = adc_rd_cnt;
    adc_data_readback = 8'h5A;
    issue(32'h1001_2300);
    @(negedge clk);
    n_checks++;
    if ({adc_request_read, adc_address} !== {1'b1, 16'h0123})
      $display("FAIL adc_strobe got %b/%h want 1/0123", adc_request_read, adc_address);
    else n_pass++;
    spi_busy = 1;
    repeat (8) @(negedge clk);
    spi_busy = 0;
    wait_rb(d);
    n_checks++;
    if (d !== 32'h1000_005A) $display("FAIL adc_read got %h want 1000005a", d); else n_pass++;
    wait_idle();
    n_checks++;
    if (adc_rd_cnt - a0 !== 1) $display("FAIL adc_read_count got %0d want 1", adc_rd_cnt - a0); else n_pass++;
  endtask
  task automatic test_bad();
    int d0;
    d0 = dac_cnt;
    issue(32'h0B40_0001);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({err_flags, cu_state} !== {3'b010, 3'd0}) $display("FAIL bad_addr got %b/%0d want 010/0", err_flags, cu_state); else n_pass++;
    n_checks++;
    if (dac_cnt - d0 !== 0) $display("FAIL bad_addr_strobe got %0d want 0", dac_cnt - d0); else n_pass++;
    issue(32'h3800_0000);
    n_checks++;
    if (cu_instr !== 5'd7) $display("FAIL cu_instr got %0d want 7", cu_instr); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_flags !== 3'b011) $display("FAIL bad_instr got %b want 011", err_flags); else n_pass++;
    issue(32'h1800_0000);
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_flags !== 3'b000) $display("FAIL clr_err got %b want 000", err_flags); else n_pass++;
  endtask
  task automatic test_timeout();
    int k = 0;
    issue(32'h0800_0155);
    @(negedge clk);
    n_checks++;
    if ({adc_request_write, adc_address, adc_data} !== {1'b1, 16'h0001, 8'h55})
      $display("FAIL adc_wr_strobe got %b/%h/%h want 1/0001/55", adc_request_write, adc_address, adc_data);
    else n_pass++;
    spi_busy = 1;
    repeat (1000) @(negedge clk);
    n_checks++;
    if ({err_flags, cu_state} !== {3'b000, 3'd3}) $display("FAIL timeout_early got %b/%0d want 000/3", err_flags, cu_state); else n_pass++;
    while (!err_flags[2] && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    n_checks++;
    if ({err_flags, cu_state} !== {3'b100, 3'd0}) $display("FAIL timeout got %b/%0d want 100/0", err_flags, cu_state); else n_pass++;
    spi_busy = 0;
    issue(32'h1800_0000);
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_flags !== 3'b000) $display("FAIL timeout_clr got %b want 000", err_flags); else n_pass++;
  endtask
  task automatic test_readback_stall();
    logic [31:0] d;
    int a0, w0;
    readback_ready = 0;
    issue(32'h1430_0000);
    @(negedge clk);
    a0 = ack_cnt;
    w0 = wr_cnt;
    instr_in = 32'h0;
    instr_ready = 1;
    repeat (50) @(negedge clk);
    n_checks++;
    if ({cu_state, 8'(ack_cnt - a0), 8'(wr_cnt - w0)} !== {3'd4, 8'd0, 8'd0})
      $display("FAIL stall got state %0d acks %0d writes %0d want 4/0/0", cu_state, ack_cnt - a0, wr_cnt - w0);
    else n_pass++;
    readback_ready = 1;
    wait_rb(d);
    n_checks++;
    if (d !== 32'h1430_BEEF) $display("FAIL stall_data got %h want 1430beef", d); else n_pass++;
    repeat (3) @(negedge clk);
    instr_ready = 0;
    n_checks++;
    if (wr_cnt - w0 !== 1) $display("FAIL stall_writes got %0d want 1", wr_cnt - w0); else n_pass++;
    wait_idle();
  endtask
  task automatic test_reset_wait_busy();
    logic [31:0] d;
    issue(32'h0A10_0123);
    @(negedge clk);
    spi_busy = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cu_state !== 3'd3) $display("FAIL in_wait_busy got %0d want 3", cu_state); else n_pass++;
    reset = 1;
    #1;
    n_checks++;
    if (all_outs() !== '0) $display("FAIL async_reset got %h want 0", all_outs()); else n_pass++;
    @(negedge clk);
    reset = 0;
    spi_busy = 0;
    @(negedge clk);
    issue(32'h1250_0000);
    wait_rb(d);
    n_checks++;
    if (d !== 32'h1250_0000) $display("FAIL shadow_cleared got %h want 12500000", d); else n_pass++;
    wait_idle();
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_int();
    test_dac();
    test_adc_read();
    test_bad();
    test_timeout();
    test_readback_stall();
    test_reset_wait_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
